// File: rtl/jump_input_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : jump_input_ctrl
// Purpose  : Producer side of the bird's jump/restart interface. Synchronises
//            and debounces the raw mouse left button, detects presses (rising
//            edges of the debounced level) and runs a small game-state FSM that
//            converts presses into 1-cycle jump (mouse_left_game) or restart
//            (game_rst) pulses. It enforces a jump cooldown while playing and
//            a click-ignore hold window after a collision.
// Ports    : clk             in   clock (65 MHz domain)
//            rst             in   synchronous, active-high reset
//            mouse_left      in   raw button level, asynchronous to clk
//            key_jump        in   clk-synchronous jump key level
//                                 (present only with JUMP_KEY_EN)
//            collision       in   bird collision level
//            mouse_left_game out  jump request, 1-cycle pulse
//            game_rst        out  restart request, 1-cycle pulse
//            game_state      out  00 IDLE, 01 PLAYING, 10 GAME_OVER
//            game_over       out  registered level, 1 iff state is GAME_OVER
// Config   : define JUMP_KEY_EN to add the key_jump input. It is ORed with the
//            synchronised mouse level ahead of the debouncer.
// Revision : 1.0 - initial release
// ============================================================================
module jump_input_ctrl #(
  parameter int SYNC_STAGES      = 2,
  parameter int DEBOUNCE_CYCLES  = 650_000,
  parameter int COOLDOWN_CYCLES  = 1_600_000,
  parameter int OVER_HOLD_CYCLES = 65_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mouse_left,
`ifdef JUMP_KEY_EN
  input  logic       key_jump,
`endif
  input  logic       collision,
  output logic       mouse_left_game,
  output logic       game_rst,
  output logic [1:0] game_state,
  output logic       game_over
);

  localparam int c_DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int c_CD_W = $clog2(COOLDOWN_CYCLES + 1);
  localparam int c_OH_W = $clog2(OVER_HOLD_CYCLES + 1);

  localparam logic [c_DB_W-1:0] c_DB_LAST = c_DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [c_DB_W-1:0] c_DB_ONE  = c_DB_W'(1);
  localparam logic [c_CD_W-1:0] c_CD_LOAD = c_CD_W'(COOLDOWN_CYCLES);
  localparam logic [c_CD_W-1:0] c_CD_ONE  = c_CD_W'(1);
  localparam logic [c_OH_W-1:0] c_OH_LOAD = c_OH_W'(OVER_HOLD_CYCLES);
  localparam logic [c_OH_W-1:0] c_OH_ONE  = c_OH_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_PLAYING = 2'b01,
    ST_OVER    = 2'b10
  } state_t;

  // --------------------------------------------------------------------------
  // Input synchroniser
  // --------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_level;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], mouse_left};
    end
  end

`ifdef JUMP_KEY_EN
  assign w_level = r_sync[SYNC_STAGES-1] | key_jump;
`else
  assign w_level = r_sync[SYNC_STAGES-1];
`endif

  // --------------------------------------------------------------------------
  // Debouncer. The debounced level resets high so that a button held through
  // reset is seen as already pressed: the user must release and press again.
  // --------------------------------------------------------------------------
  logic              r_deb;
  logic              r_deb_d;
  logic [c_DB_W-1:0] r_db_cnt;
  logic              w_press;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_deb    <= 1'b1;
      r_deb_d  <= 1'b1;
      r_db_cnt <= '0;
    end else begin
      r_deb_d <= r_deb;
      if (w_level == r_deb) begin
        r_db_cnt <= '0;
      end else if (r_db_cnt == c_DB_LAST) begin
        // This is the DEBOUNCE_CYCLES-th consecutive disagreeing sample.
        r_deb    <= w_level;
        r_db_cnt <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + c_DB_ONE;
      end
    end
  end

  assign w_press = r_deb & ~r_deb_d;

  // --------------------------------------------------------------------------
  // Game-state FSM. All outputs are registered from the next-state logic.
  // --------------------------------------------------------------------------
  state_t            r_state;
  state_t            w_state_nxt;
  logic [c_CD_W-1:0] r_cool;
  logic [c_CD_W-1:0] w_cool_nxt;
  logic [c_OH_W-1:0] r_hold;
  logic [c_OH_W-1:0] w_hold_nxt;
  logic              r_jump;
  logic              w_jump_nxt;
  logic              r_game_rst;
  logic              w_game_rst_nxt;
  logic              r_game_over;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cool      <= '0;
      r_hold      <= '0;
      r_jump      <= 1'b0;
      r_game_rst  <= 1'b0;
      r_game_over <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cool      <= w_cool_nxt;
      r_hold      <= w_hold_nxt;
      r_jump      <= w_jump_nxt;
      r_game_rst  <= w_game_rst_nxt;
      r_game_over <= (w_state_nxt == ST_OVER);
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_jump_nxt     = 1'b0;
    w_game_rst_nxt = 1'b0;
    // Both timers count down and stick at zero unless reloaded below.
    w_cool_nxt     = (r_cool != '0) ? (r_cool - c_CD_ONE) : r_cool;
    w_hold_nxt     = (r_hold != '0) ? (r_hold - c_OH_ONE) : r_hold;

    case (r_state)
      ST_IDLE: begin
        w_cool_nxt = '0;
        w_hold_nxt = '0;
        if (w_press) begin
          w_jump_nxt  = 1'b1;
          w_cool_nxt  = c_CD_LOAD;
          w_state_nxt = ST_PLAYING;
        end
      end
      ST_PLAYING: begin
        // A collision takes priority over a press in the same cycle.
        if (collision) begin
          w_state_nxt = ST_OVER;
          w_hold_nxt  = c_OH_LOAD;
        end else if (w_press && (r_cool == '0)) begin
          w_jump_nxt = 1'b1;
          w_cool_nxt = c_CD_LOAD;
        end
      end
      ST_OVER: begin
        // The restarting click is consumed here; it never becomes a jump.
        if (w_press && (r_hold == '0)) begin
          w_game_rst_nxt = 1'b1;
          w_cool_nxt     = '0;
          w_state_nxt    = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cool_nxt  = '0;
        w_hold_nxt  = '0;
      end
    endcase
  end

  assign mouse_left_game = r_jump;
  assign game_rst        = r_game_rst;
  assign game_state      = r_state;
  assign game_over       = r_game_over;

endmodule
`default_nettype wire
